// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode, transmitter states and the frame-length helper
// that the receiver will reuse.
package uart_pkg;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_ODD  = 2'd1,
        PARITY_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Bit periods in one frame: start + data + optional parity + stop.
    function automatic int unsigned frame_bits(input int unsigned data_bits,
                                               input int unsigned stop_bits,
                                               input parity_e     parity);
        return 32'd1 + data_bits + ((parity == PARITY_NONE) ? 32'd0 : 32'd1) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on data_o whenever empty_o is low.
// Pushes while full and pops while empty are ignored.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // NOTE: the storage array has no reset; the pointers and count alone decide which
    // entries are valid, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter: buffered byte stream in, LSB-first frames out with a runtime divisor,
// optional parity and back-to-back frames while data is queued.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int      DATA_BITS  = 8,
    parameter int      STOP_BITS  = 1,
    parameter parity_e PARITY     = PARITY_NONE,
    parameter int      DIV_WIDTH  = 16,
    parameter int      FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DIV_WIDTH-1:0]          clks_per_bit,
    input  logic [DATA_BITS-1:0]          in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam logic [3:0]           LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]           LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE   = DIV_WIDTH'(1);

    tx_state_e             state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [DIV_WIDTH-1:0]  baud_q, baud_d;
    logic [3:0]            bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  parity_q, parity_d;
    logic                  tx_q, tx_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic [DATA_BITS-1:0]  fifo_head;
    logic                  load;
    logic                  bit_end;

    assign fifo_push = in_valid && !fifo_full;
    assign in_ready  = !fifo_full;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (in_data),
        .pop_i   (load),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign bit_end = (baud_q == div_q - DIV_ONE);

    // NOTE: every signal written here gets its default before any branch, so no path
    // leaves a value unassigned and no latch can be inferred.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        load     = 1'b0;

        if (state_q != ST_IDLE) begin
            baud_d = bit_end ? '0 : baud_q + DIV_ONE;
        end

        unique case (state_q)
            ST_IDLE: begin
                load = !fifo_empty;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Frame start: parity is taken from the whole byte now, before any shifting.
        if (load) begin
            state_d  = ST_START;
            shift_d  = fifo_head;
            div_d    = (clks_per_bit == '0) ? DIV_ONE : clks_per_bit;
            baud_d   = '0;
            bit_d    = '0;
            parity_d = (PARITY == PARITY_ODD) ? ~^fifo_head : ^fifo_head;
        end

        // The pin level follows the next state so the registered tx lines up with it.
        tx_d = 1'b1;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values and the order of statements inside the block does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            div_q    <= DIV_ONE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != ST_IDLE) || !fifo_empty;

endmodule
